req_rr_issuer: RTL and testbench
================================

Name: req_rr_issuer

Overview:
- Upstream stage of the request/grant delay controller.
- Collects level requests from NUM_CLIENTS clients and picks one round-robin.
- Sends a single-cycle req pulse downstream, then waits for the downstream grnt to rise within a bounded window.
- Returns a one-cycle ack (grant seen) or err (timeout) to the selected client.

Parameters:
- NUM_CLIENTS, 4, number of requesting clients (legal range 2..16).
- TIMEOUT, 6, WAIT cycles allowed for a grnt rising edge before the transaction fails (must be ≥1).
- IDW, $clog2(NUM_CLIENTS), width of grant_id (derived; do not override).

Ports:
- clk  in  1  single clock; all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- client_req  in  NUM_CLIENTS  per-client request level; held until that client's ack or err.
- client_ack  out  NUM_CLIENTS  one-hot one-cycle pulse: transaction granted.
- client_err  out  NUM_CLIENTS  one-hot one-cycle pulse: transaction timed out.
- req  out  1  one-cycle request pulse to the downstream grant controller.
- grnt  in  1  grant level from the downstream controller.
- grant_id  out  IDW  index of the client currently in flight.
- busy  out  1  high in ISSUE and WAIT.

Behaviour:
- Reset (async assert, sync deassert release): all outputs 0, state=IDLE, rr_ptr=0, tmo_cnt=0, grnt_q=0.
- Reset mid-transaction aborts it silently: no ack, no err.
- grnt_q is a register of grnt, updated every cycle in every state. grnt_rise = grnt & ~grnt_q.
- FSM states: IDLE, ISSUE, WAIT. All outputs are registered.
- IDLE:
  - Effective request vector = client_req with the bit masked whose client_ack or client_err is high this cycle. This prevents re-selecting a client in the same cycle it is acked.
  - If the vector is non-zero, pick the first set bit scanning upward from rr_ptr, wrapping at NUM_CLIENTS-1 → 0.
  - On that pick: grant_id <= index, req <= 1, busy <= 1, state -> ISSUE.
  - Otherwise remain in IDLE with req=0 and busy=0.
- ISSUE (exactly 1 cycle; req=1 during it):
  - req <= 0, tmo_cnt <= 0, state -> WAIT.
  - A grnt_rise during ISSUE is ignored.
- WAIT (req=0, busy=1):
  - If grnt_rise: client_ack[grant_id] <= 1 for one cycle, state -> IDLE, rr_ptr <= (grant_id+1) mod NUM_CLIENTS.
  - Else if tmo_cnt == TIMEOUT-1: client_err[grant_id] <= 1 for one cycle, state -> IDLE, rr_ptr advances the same way.
  - Else tmo_cnt <= tmo_cnt+1.
  - grnt_rise in the same cycle as timeout expiry: ack wins, no err.
  - grnt held high from a previous transaction does not count; only a rising edge is accepted.
- Latency: the req pulse is visible 1 cycle after IDLE samples a request. Minimum turnaround from req pulse to ack pulse is 2 cycles. Back-to-back transactions are separated by at least one IDLE cycle.
- Client dropping client_req while in flight: the transaction still completes and ack/err is still pulsed.
- Counter widths:
  - tmo_cnt is $clog2(TIMEOUT+1) bits and never wraps.
  - rr_ptr is IDW bits with explicit modulo for non-power-of-2 NUM_CLIENTS.
- client_ack and client_err are never both non-zero, and each is at most one-hot.
- grant_id holds its value after the transaction until the next selection.

Test Plan:
- Reset and single request: rst_n low 3 cycles, then client_req=4'b0010.
  - req pulses in the cycle after sampling, grant_id=1.
  - Downstream model raises grnt 2 cycles after the req pulse → client_ack=4'b0010 pulses exactly once.
  - busy returns to 0; rr_ptr=2.
- Round-robin fairness: client_req=4'b1111 held; each client drops its request on ack and re-raises it one cycle later.
  - Grant order is 0,1,2,3,0.
  - No client is served twice before all others are served.
- Timeout: grnt tied 0, client_req=4'b0100.
  - client_err=4'b0100 pulses exactly TIMEOUT=6 cycles after WAIT entry; no ack.
  - Next selection starts scanning from client 3.
- Stale grant level: grnt stuck at 1 from before the req pulse, then held at 1.
  - No rising edge occurs → err after 6 WAIT cycles.
  - Repeat with grnt dropping to 0 in ISSUE and rising in WAIT cycle 3 → ack, no err.
- Simultaneous events:
  - grnt rises on the cycle tmo_cnt==5 → only ack asserts.
  - Sole client 0 keeps its request high through the ack cycle → it is not reselected in that IDLE cycle; it is reselected one cycle later.
- Async reset mid-WAIT: rst_n asserted asynchronously while in WAIT.
  - req, busy, client_ack and client_err drop immediately with no ack/err pulse.
  - After release, the state is IDLE and rr_ptr=0.

Source files
------------

// File: rtl/req_rr_issuer.sv
// rtl/req_rr_issuer.sv - round-robin request issuer with bounded grant wait
// Picks one requesting client, pulses req downstream, returns ack on grnt rise or err on timeout.
module req_rr_issuer #(
    parameter int NUM_CLIENTS = 4,
    parameter int TIMEOUT     = 6,
    parameter int IDW         = $clog2(NUM_CLIENTS)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_CLIENTS-1:0] client_req,
    output logic [NUM_CLIENTS-1:0] client_ack,
    output logic [NUM_CLIENTS-1:0] client_err,
    output logic                   req,
    input  logic                   grnt,
    output logic [IDW-1:0]         grant_id,
    output logic                   busy
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [IDW:0] NC = (IDW + 1)'(NUM_CLIENTS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t                   state, state_d;
    logic [IDW-1:0]           rr_ptr, rr_ptr_d;
    logic [IDW-1:0]           grant_id_d, pick_idx, next_ptr;
    logic [IDW:0]             scan_idx;
    logic                     pick_valid;
    logic [TW-1:0]            tmo_cnt, tmo_cnt_d;
    logic                     grnt_q, grnt_rise;
    logic [NUM_CLIENTS-1:0]   eff_req, ack_d, err_d;
    logic                     req_d, busy_d;

    assign grnt_rise = grnt & ~grnt_q;

    // A client whose ack/err is on the wire right now must not be picked again this cycle.
    assign eff_req = client_req & ~(client_ack | client_err);

    assign next_ptr = (grant_id == IDW'(NUM_CLIENTS - 1)) ? '0 : grant_id + IDW'(1);

    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        scan_idx   = '0;
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            if (!pick_valid) begin
                scan_idx = {1'b0, rr_ptr} + (IDW + 1)'(i);
                if (scan_idx >= NC) begin
                    scan_idx = scan_idx - NC;
                end
                if (eff_req[scan_idx[IDW-1:0]]) begin
                    pick_valid = 1'b1;
                    pick_idx   = scan_idx[IDW-1:0];
                end
            end
        end
    end

    always_comb begin
        state_d    = state;
        rr_ptr_d   = rr_ptr;
        grant_id_d = grant_id;
        tmo_cnt_d  = tmo_cnt;
        req_d      = 1'b0;
        busy_d     = busy;
        ack_d      = '0;
        err_d      = '0;
        case (state)
            IDLE: begin
                busy_d = 1'b0;
                if (pick_valid) begin
                    grant_id_d = pick_idx;
                    req_d      = 1'b1;
                    busy_d     = 1'b1;
                    state_d    = ISSUE;
                end
            end
            ISSUE: begin
                tmo_cnt_d = '0;
                busy_d    = 1'b1;
                state_d   = WAIT;
            end
            WAIT: begin
                // Ack has priority over a timeout expiring in the same cycle.
                if (grnt_rise) begin
                    ack_d[grant_id] = 1'b1;
                    busy_d          = 1'b0;
                    rr_ptr_d        = next_ptr;
                    state_d         = IDLE;
                end else if (tmo_cnt == TW'(TIMEOUT - 1)) begin
                    err_d[grant_id] = 1'b1;
                    busy_d          = 1'b0;
                    rr_ptr_d        = next_ptr;
                    state_d         = IDLE;
                end else begin
                    tmo_cnt_d = tmo_cnt + TW'(1);
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            grant_id   <= '0;
            tmo_cnt    <= '0;
            grnt_q     <= 1'b0;
            req        <= 1'b0;
            busy       <= 1'b0;
            client_ack <= '0;
            client_err <= '0;
        end else begin
            state      <= state_d;
            rr_ptr     <= rr_ptr_d;
            grant_id   <= grant_id_d;
            tmo_cnt    <= tmo_cnt_d;
            grnt_q     <= grnt;
            req        <= req_d;
            busy       <= busy_d;
            client_ack <= ack_d;
            client_err <= err_d;
        end
    end

endmodule

// File: tb/tb_req_rr_issuer.sv
// tb/tb_req_rr_issuer.sv - directed self-checking bench for req_rr_issuer
module tb_req_rr_issuer;

    logic       clk;
    logic       rst_n;
    logic [3:0] client_req;
    logic [3:0] client_ack;
    logic [3:0] client_err;
    logic       req;
    logic       grnt;
    logic [1:0] grant_id;
    logic       busy;

    int checks = 0;
    int errors = 0;

    req_rr_issuer #(.NUM_CLIENTS(4), .TIMEOUT(6)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .client_req (client_req),
        .client_ack (client_ack),
        .client_err (client_err),
        .req        (req),
        .grnt       (grnt),
        .grant_id   (grant_id),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst_n      = 1'b0;
        client_req = 4'b0000;
        grnt       = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
    endtask

    task automatic wait_req(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (req === 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset;
        rst_n      = 1'b0;
        client_req = 4'b0000;
        grnt       = 1'b0;
        repeat (3) tick();
        checks++; if (req !== 1'b0) begin errors++; $display("FAIL reset_req: got %0b expected 0", req); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b expected 0", busy); end
        checks++; if (client_ack !== 4'b0000) begin errors++; $display("FAIL reset_ack: got %b expected 0000", client_ack); end
        checks++; if (client_err !== 4'b0000) begin errors++; $display("FAIL reset_err: got %b expected 0000", client_err); end
        checks++; if (grant_id !== 2'd0) begin errors++; $display("FAIL reset_grant_id: got %0d expected 0", grant_id); end
        checks++; if (dut.rr_ptr !== 2'd0) begin errors++; $display("FAIL reset_rr_ptr: got %0d expected 0", dut.rr_ptr); end
        rst_n = 1'b1;
    endtask

    task automatic test_single;
        client_req = 4'b0010;
        tick();
        checks++; if (req !== 1'b1) begin errors++; $display("FAIL single_req_pulse: got %0b expected 1", req); end
        checks++; if (grant_id !== 2'd1) begin errors++; $display("FAIL single_grant_id: got %0d expected 1", grant_id); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_issue: got %0b expected 1", busy); end
        tick();
        checks++; if (req !== 1'b0) begin errors++; $display("FAIL single_req_one_cycle: got %0b expected 0", req); end
        tick();
        grnt = 1'b1;
        checks++; if (client_ack !== 4'b0000) begin errors++; $display("FAIL single_early_ack: got %b expected 0000", client_ack); end
        tick();
        checks++; if (client_ack !== 4'b0010) begin errors++; $display("FAIL single_ack: got %b expected 0010", client_ack); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_done: got %0b expected 0", busy); end
        client_req = 4'b0000;
        grnt       = 1'b0;
        tick();
        checks++; if (client_ack !== 4'b0000) begin errors++; $display("FAIL single_ack_once: got %b expected 0000", client_ack); end
        checks++; if (dut.rr_ptr !== 2'd2) begin errors++; $display("FAIL single_rr_ptr: got %0d expected 2", dut.rr_ptr); end
    endtask

    task automatic test_round_robin;
        int         exp_order[5] = '{0, 1, 2, 3, 0};
        logic [3:0] exp_ack;
        bit         ok;
        do_reset();
        client_req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            exp_ack = 4'b0001 << exp_order[k];
            wait_req(ok);
            checks++; if (!ok) begin errors++; $display("FAIL rr_req_timeout[%0d]: got no req expected req", k); end
            checks++; if (grant_id !== 2'(exp_order[k])) begin errors++; $display("FAIL rr_order[%0d]: got %0d expected %0d", k, grant_id, exp_order[k]); end
            tick();
            grnt = 1'b1;
            tick();
            checks++; if (client_ack !== exp_ack) begin errors++; $display("FAIL rr_ack[%0d]: got %b expected %b", k, client_ack, exp_ack); end
            client_req = client_req & ~exp_ack;
            grnt       = 1'b0;
            tick();
            client_req = client_req | exp_ack;
        end
        client_req = 4'b0000;
    endtask

    task automatic test_timeout;
        bit ok;
        bit err_seen;
        bit ack_seen;
        int n;
        do_reset();
        client_req = 4'b0100;
        wait_req(ok);
        checks++; if (!ok) begin errors++; $display("FAIL tmo_req_timeout: got no req expected req"); end
        checks++; if (grant_id !== 2'd2) begin errors++; $display("FAIL tmo_grant_id: got %0d expected 2", grant_id); end
        tick();
        err_seen = 1'b0; ack_seen = 1'b0; n = 0;
        for (int i = 1; i <= 10 && !err_seen; i++) begin
            tick();
            if (client_ack !== 4'b0000) ack_seen = 1'b1;
            if (client_err !== 4'b0000) begin err_seen = 1'b1; n = i; end
        end
        checks++; if (n != 6) begin errors++; $display("FAIL tmo_latency: got %0d expected 6", n); end
        checks++; if (client_err !== 4'b0100) begin errors++; $display("FAIL tmo_err: got %b expected 0100", client_err); end
        checks++; if (ack_seen) begin errors++; $display("FAIL tmo_no_ack: got ack expected none"); end
        client_req = 4'b0000;
        tick();
        checks++; if (client_err !== 4'b0000) begin errors++; $display("FAIL tmo_err_once: got %b expected 0000", client_err); end
        client_req = 4'b1001;
        wait_req(ok);
        checks++; if (grant_id !== 2'd3) begin errors++; $display("FAIL tmo_next_scan: got %0d expected 3", grant_id); end
        client_req = 4'b0000;
    endtask

    task automatic test_stale_grant;
        bit ok;
        bit err_seen;
        bit ack_seen;
        int n;
        do_reset();
        grnt = 1'b1;
        tick();
        tick();
        client_req = 4'b0001;
        wait_req(ok);
        checks++; if (!ok) begin errors++; $display("FAIL stale_req_timeout: got no req expected req"); end
        tick();
        err_seen = 1'b0; ack_seen = 1'b0; n = 0;
        for (int i = 1; i <= 10 && !err_seen; i++) begin
            tick();
            if (client_ack !== 4'b0000) ack_seen = 1'b1;
            if (client_err !== 4'b0000) begin err_seen = 1'b1; n = i; end
        end
        checks++; if (n != 6) begin errors++; $display("FAIL stale_err_latency: got %0d expected 6", n); end
        checks++; if (ack_seen) begin errors++; $display("FAIL stale_no_ack: got ack expected none"); end
        client_req = 4'b0000;
        tick();

        do_reset();
        grnt = 1'b1;
        tick();
        client_req = 4'b0001;
        wait_req(ok);
        grnt = 1'b0;
        tick();
        tick();
        tick();
        checks++; if (client_ack !== 4'b0000) begin errors++; $display("FAIL stale2_early_ack: got %b expected 0000", client_ack); end
        grnt = 1'b1;
        tick();
        checks++; if (client_ack !== 4'b0001) begin errors++; $display("FAIL stale2_ack: got %b expected 0001", client_ack); end
        checks++; if (client_err !== 4'b0000) begin errors++; $display("FAIL stale2_no_err: got %b expected 0000", client_err); end
        client_req = 4'b0000;
        grnt       = 1'b0;
        tick();
    endtask

    task automatic test_simultaneous;
        bit ok;
        do_reset();
        client_req = 4'b0001;
        wait_req(ok);
        checks++; if (!ok) begin errors++; $display("FAIL sim_req_timeout: got no req expected req"); end
        tick();
        repeat (5) tick();
        checks++; if (dut.tmo_cnt !== 3'd5) begin errors++; $display("FAIL sim_tmo_cnt: got %0d expected 5", dut.tmo_cnt); end
        checks++; if (client_err !== 4'b0000) begin errors++; $display("FAIL sim_early_err: got %b expected 0000", client_err); end
        grnt = 1'b1;
        tick();
        checks++; if (client_ack !== 4'b0001) begin errors++; $display("FAIL sim_ack_wins: got %b expected 0001", client_ack); end
        checks++; if (client_err !== 4'b0000) begin errors++; $display("FAIL sim_no_err: got %b expected 0000", client_err); end
        grnt = 1'b0;
        tick();
        checks++; if (req !== 1'b0) begin errors++; $display("FAIL sim_no_reselect: got %0b expected 0", req); end
        checks++; if (client_err !== 4'b0000) begin errors++; $display("FAIL sim_no_late_err: got %b expected 0000", client_err); end
        tick();
        checks++; if (req !== 1'b1) begin errors++; $display("FAIL sim_reselect: got %0b expected 1", req); end
        checks++; if (grant_id !== 2'd0) begin errors++; $display("FAIL sim_reselect_id: got %0d expected 0", grant_id); end
        client_req = 4'b0000;
    endtask

    task automatic test_async_reset;
        bit ok;
        do_reset();
        client_req = 4'b0010;
        wait_req(ok);
        tick();
        tick();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL arst_busy_wait: got %0b expected 1", busy); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (req !== 1'b0) begin errors++; $display("FAIL arst_req: got %0b expected 0", req); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL arst_busy: got %0b expected 0", busy); end
        checks++; if ((client_ack | client_err) !== 4'b0000) begin errors++; $display("FAIL arst_ack_err: got %b expected 0000", client_ack | client_err); end
        grnt = 1'b1;
        tick();
        client_req = 4'b0000;
        rst_n = 1'b1;
        checks++; if (dut.rr_ptr !== 2'd0) begin errors++; $display("FAIL arst_rr_ptr: got %0d expected 0", dut.rr_ptr); end
        tick();
        checks++; if ((client_ack | client_err) !== 4'b0000) begin errors++; $display("FAIL arst_no_pulse: got %b expected 0000", client_ack | client_err); end
        grnt       = 1'b0;
        client_req = 4'b0100;
        tick();
        checks++; if (req !== 1'b1) begin errors++; $display("FAIL arst_idle_pick: got %0b expected 1", req); end
        checks++; if (grant_id !== 2'd2) begin errors++; $display("FAIL arst_idle_id: got %0d expected 2", grant_id); end
        client_req = 4'b0000;
    endtask

    initial begin
        rst_n      = 1'b0;
        client_req = 4'b0000;
        grnt       = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_timeout();
        test_stale_grant();
        test_simultaneous();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
